mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single unified instruction/data memory of the multi-cycle processor between two requesters:
  - the CPU port, driven by the processor's fetch/load/store address mux;
  - a DMA/loader port, used for program load and debug access.
- Sequences each access through a small FSM, holds the memory bus for a configurable number of cycles and returns a one-cycle completion pulse with read data.
- The CPU controller treats `cpu_req && !cpu_done` as a stall condition.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MEM_LAT, 1, memory cycles per access (>=1); the bus is held this many cycles.
- CPU_PRIO, 0, 0 = round-robin arbitration; 1 = CPU always wins a simultaneous request.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- cpu_req  in  1  CPU access request; held high with fields stable until cpu_done.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_done  out  1  one-cycle completion pulse.
- dma_req  in  1  DMA request; same rules as cpu_req.
- dma_we  in  1  DMA write enable.
- dma_addr  in  AW  DMA address.
- dma_wdata  in  DW  DMA write data.
- dma_done  out  1  one-cycle completion pulse.
- rdata  out  DW  read data; valid in the cycle cpu_done or dma_done is high.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; valid at the end of the last BUSY cycle.
- busy  out  1  high in BUSY or RESP.
- owner  out  1  0 = CPU, 1 = DMA; owner of the current or last access.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; all outputs 0, including rdata, owner and the mem_* signals; counter=0.
  - last_grant=DMA, so the CPU wins the first tie.
  - Reset during BUSY aborts the access: mem_en/mem_we drop immediately and no done pulse is issued.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If cpu_req or dma_req is high, select a winner:
    - only one requester asserted: that requester wins;
    - both asserted, CPU_PRIO=1: CPU wins;
    - both asserted, CPU_PRIO=0: the requester that is not last_grant wins.
  - On selection, latch owner, we, addr and wdata of the winner; last_grant<=winner; counter<=MEM_LAT; go to BUSY.
  - No request: stay in IDLE.
- BUSY:
  - mem_en=1; mem_we, mem_addr and mem_wdata come from the latched registers, not live inputs.
  - counter decrements each cycle.
  - When counter==1: rdata<=mem_rdata (read only; rdata is unchanged on a write); go to RESP.
  - mem_we is held for all BUSY cycles; the memory tolerates repeated identical writes.
- RESP:
  - mem_en=0; the owner's done=1 for exactly one cycle; go to IDLE.
  - Requests are not sampled in RESP.
- Latency:
  - Request first seen in IDLE at cycle t: BUSY occupies t+1 .. t+MEM_LAT; done is high at t+MEM_LAT+1.
  - MEM_LAT=1 gives done 2 cycles after the request.
  - Back-to-back throughput is one access per MEM_LAT+2 cycles.
- Requester protocol:
  - A requester may deassert req in the cycle after its done; a req still high in that cycle starts a new access.
  - If req drops during BUSY, the access still completes and done still pulses.
  - Input changes after the IDLE sampling cycle are ignored.
- Invariants:
  - At most one of cpu_done and dma_done is high in any cycle; never both.
  - mem_en is never high in IDLE or RESP.
- Fairness: under continuous dual requests with CPU_PRIO=0, grants alternate CPU, DMA, CPU, ...; no starvation.
- rdata keeps its value until the next read completes.
- owner stays valid after completion, for debug.

Test Plan:
1. Reset, then a CPU read of addr 0x20 with MEM_LAT=1 and the memory returning 0xE3A00005 → mem_en high for 1 cycle with mem_addr=0x20; cpu_done pulses 2 cycles after cpu_req; rdata=0xE3A00005; dma_done stays 0.
2. DMA write of addr 0x40, data 0xDEADBEEF, MEM_LAT=3 → mem_en=mem_we=1 for exactly 3 cycles with the latched address/data, even though dma_addr is changed to 0x44 mid-access; dma_done pulses at t+4.
3. cpu_req and dma_req asserted together and held, CPU_PRIO=0, for 4 accesses → grant order CPU, DMA, CPU, DMA; owner matches; done pulses are never simultaneous.
4. Same as scenario 3 with CPU_PRIO=1 → the CPU wins every access while cpu_req is held; DMA is granted only after cpu_req drops.
5. reset asserted in the 2nd BUSY cycle of a MEM_LAT=3 write → mem_en/mem_we go to 0 asynchronously; no done pulse; after release the FSM is IDLE and the next tie goes to the CPU.
6. CPU drops cpu_req in its 1st BUSY cycle → the access completes and cpu_done still pulses once; the FSM returns to IDLE with no further mem_en.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (CPU / DMA) arbiter in front of the single unified memory.
// Each access is sequenced IDLE -> BUSY (MEM_LAT cycles) -> RESP (one-cycle done pulse).
module mem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MEM_LAT  = 1,
  parameter int CPU_PRIO = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_done,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_done,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  localparam int CW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] LAT_C = CW'(MEM_LAT);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          last_q, last_d;   // 0 = CPU, 1 = DMA got the previous grant
  logic          grant_dma;

  // On a tie, round-robin hands the grant to whoever did not win last time.
  assign grant_dma = dma_req & (~cpu_req | ((CPU_PRIO == 0) & ~last_q));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_req || dma_req) begin
          owner_d = grant_dma;
          we_d    = grant_dma ? dma_we    : cpu_we;
          addr_d  = grant_dma ? dma_addr  : cpu_addr;
          wdata_d = grant_dma ? dma_wdata : cpu_wdata;
          last_d  = grant_dma;
          cnt_d   = LAT_C;
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - ONE_C;
        if (cnt_q == ONE_C) begin
          if (!we_q) rdata_d = mem_rdata;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs come from the latched request, never from live requester inputs.
  assign mem_en    = (state_q == BUSY);
  assign mem_we    = (state_q == BUSY) & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_done  = (state_q == RESP) & ~owner_q;
  assign dma_done  = (state_q == RESP) & owner_q;
  assign busy      = (state_q != IDLE);
  assign owner     = owner_q;
  assign rdata     = rdata_q;

endmodule
